seg_scan_monitor: RTL and testbench

- Receive-side counterpart of the top-level multiplexed seven-segment driver.
- Samples the scanned anode and segment lines (`an`, `a_to_g`), decodes each digit's segment pattern back to a hex nibble, and assembles a full 32-bit display frame.
- Sits beside `top` in the simulation and FPGA-loopback environment so that displayed results (e.g. GEMM outputs) can be checked numerically instead of visually.

---
 rtl/seg_scan_monitor.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_monitor.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_monitor.sv
// Seven-segment scan monitor: samples multiplexed anode/segment lines, decodes each
// settled digit back to a hex nibble and assembles full frames. Optional watchdog: SEG_MONITOR_TIMEOUT_EN.
module seg_scan_monitor #(
  parameter int DIGITS         = 8,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            a_to_g,
  input  logic                  err_clr,
  output logic [4*DIGITS-1:0]   value,
  output logic                  frame_valid,
  output logic [DIGITS-1:0]     digit_mask,
  output logic                  seg_err,
  output logic                  an_err,
  output logic                  stale
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state, state_nxt;

  logic [DIGITS-1:0]   an_n, an_r;
  logic [6:0]          seg_n, seg_r;
  logic [7:0]          cnt;
  logic [4*DIGITS-1:0] shadow, shadow_upd;
  logic [DIGITS-1:0]   mask_upd;
  logic [IW-1:0]       idx;
  logic [3:0]          nib;
  logic                glyph_ok, an_any, an_one, changed, settled;
  logic                do_eval, cap_ok, seg_set, an_set, frame_done;

  assign an_n  = (AN_ACTIVE_LOW != 0)  ? ~an     : an;
  assign seg_n = (SEG_ACTIVE_LOW != 0) ? ~a_to_g : a_to_g;

  // The counter compares against the previous registered sample, so it is 0 on the
  // first cycle a new value is visible and reaches SETTLE_CYCLES-1 on the last required sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_r  <= '0;
      seg_r <= '0;
      cnt   <= '0;
    end else begin
      an_r  <= an_n;
      seg_r <= seg_n;
      if ({an_n, seg_n} == {an_r, seg_r})
        cnt <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
      else
        cnt <= '0;
    end
  end

  assign changed = (cnt == 8'd0);
  assign settled = (cnt == SETTLE_M1);
  assign an_any  = |an_r;
  assign an_one  = an_any && ((an_r & (an_r - DIGITS'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++)
      if (an_r[i]) idx = IW'(i);
  end

  always_comb begin
    glyph_ok = 1'b1;
    nib      = 4'h0;
    case (seg_r)
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
      default: glyph_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    do_eval   = 1'b0;
    cap_ok    = 1'b0;
    seg_set   = 1'b0;
    an_set    = 1'b0;
    case (state)
      IDLE, SETTLE: do_eval = 1'b1;
      HOLD:         do_eval = changed;
      default:      state_nxt = IDLE;
    endcase
    if (do_eval) begin
      if (!an_any) begin
        state_nxt = IDLE;
      end else if (settled) begin
        state_nxt = HOLD;
        if (!an_one)       an_set  = 1'b1;
        else if (glyph_ok) cap_ok  = 1'b1;
        else               seg_set = 1'b1;
      end else begin
        state_nxt = SETTLE;
      end
    end
  end

  always_comb begin
    shadow_upd             = shadow;
    shadow_upd[idx*4 +: 4] = nib;
  end

  assign mask_upd   = digit_mask | an_r;
  assign frame_done = cap_ok && (&mask_upd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      shadow      <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      digit_mask  <= '0;
      seg_err     <= 1'b0;
      an_err      <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_valid <= frame_done;
      if (cap_ok) begin
        shadow <= shadow_upd;
        if (frame_done) begin
          value      <= shadow_upd;
          digit_mask <= '0;
        end else begin
          digit_mask <= mask_upd;
        end
      end
      // A new error in the same cycle as err_clr keeps the flag set.
      seg_err <= seg_set | (seg_err & ~err_clr);
      an_err  <= an_set  | (an_err  & ~err_clr);
    end
  end

`ifdef SEG_MONITOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt;

  // Cleared on the same edge that raises frame_valid, so stale drops on that pulse's cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      to_cnt <= '0;
    else if (frame_done)
      to_cnt <= '0;
    else if (to_cnt != TO_MAX)
      to_cnt <= to_cnt + TW'(1);
  end

  assign stale = (to_cnt == TO_MAX);
`else
  assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_monitor.sv
// Bench for seg_scan_monitor: drives active-low scans; a frame scoreboard compares
// every frame_valid pulse against expected frames queued by the scan driver.
module tb_seg_scan_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  an;
  logic [6:0]  a_to_g;
  logic        err_clr;
  logic [31:0] value;
  logic        frame_valid;
  logic [7:0]  digit_mask;
  logic        seg_err, an_err, stale;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  seg_scan_monitor #(
    .DIGITS(8), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1),
    .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst), .an(an), .a_to_g(a_to_g), .err_clr(err_clr),
    .value(value), .frame_valid(frame_valid), .digit_mask(digit_mask),
    .seg_err(seg_err), .an_err(an_err), .stale(stale)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h7E;  4'h1: glyph = 7'h30;  4'h2: glyph = 7'h6D;  4'h3: glyph = 7'h79;
      4'h4: glyph = 7'h33;  4'h5: glyph = 7'h5B;  4'h6: glyph = 7'h5F;  4'h7: glyph = 7'h70;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h7B;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h1F;
      4'hC: glyph = 7'h4E;  4'hD: glyph = 7'h3D;  4'hE: glyph = 7'h4F;  default: glyph = 7'h47;
    endcase
  endfunction

  // Scoreboard: every frame_valid pulse pops one expected frame.
  always @(negedge clk) begin
    if (frame_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL frame_unexpected: got value=%h, required no frame", value);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (value !== e) $display("FAIL frame_value: got %h, required %h", value, e);
        else n_pass++;
      end
      n_checks++;
      if (stale !== 1'b0) $display("FAIL stale_on_frame: got %b, required 0", stale);
      else n_pass++;
    end
  end

  task automatic drive_digit(input int d, input logic [6:0] pat, input int cyc);
    logic [7:0] one;
    one    = 8'b1 << d;
    an     = ~one;
    a_to_g = ~pat;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic blank(input int cyc);
    an     = 8'hFF;
    a_to_g = 7'h7F;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic scan(input logic [31:0] v);
    exp_q.push_back(v);
    for (int d = 7; d >= 0; d--) drive_digit(d, glyph(v[4*d +: 4]), 10);
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    n_checks++;
    if (got !== req) $display("FAIL %s: got %b, required %b", name, got, req);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b0; err_clr = 1'b0; an = 8'hFF; a_to_g = 7'h7F;
    repeat (3) @(negedge clk);
    n_checks++;
    if (value !== 32'h0) $display("FAIL reset_value: got %h, required 0", value); else n_pass++;
    n_checks++;
    if (digit_mask !== 8'h0) $display("FAIL reset_mask: got %h, required 0", digit_mask); else n_pass++;
    check_bit("reset_frame_valid", frame_valid, 1'b0);
    check_bit("reset_seg_err", seg_err, 1'b0);
    check_bit("reset_an_err", an_err, 1'b0);
    check_bit("reset_stale", stale, 1'b0);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_deadbeef();
    scan(32'hDEADBEEF);
    blank(5);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL deadbeef_frames: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    n_checks++;
    if (value !== 32'hDEADBEEF) $display("FAIL deadbeef_value: got %h, required deadbeef", value);
    else n_pass++;
    n_checks++;
    if (digit_mask !== 8'h0) $display("FAIL deadbeef_mask: got %h, required 0", digit_mask);
    else n_pass++;
    check_bit("deadbeef_seg_err", seg_err, 1'b0);
  endtask

  task automatic test_glitch();
    exp_q.push_back(32'h87651432);
    drive_digit(7, glyph(4'h8), 10);
    drive_digit(6, glyph(4'h7), 10);
    drive_digit(5, glyph(4'h6), 10);
    drive_digit(4, glyph(4'h5), 10);
    drive_digit(3, 7'h7E, 2);
    n_checks++;
    if (digit_mask !== 8'hF0) $display("FAIL glitch_no_capture: got mask %h, required f0", digit_mask);
    else n_pass++;
    drive_digit(3, 7'h30, 8);
    n_checks++;
    if (digit_mask !== 8'hF8) $display("FAIL glitch_capture: got mask %h, required f8", digit_mask);
    else n_pass++;
    drive_digit(2, glyph(4'h4), 10);
    drive_digit(1, glyph(4'h3), 10);
    drive_digit(0, glyph(4'h2), 10);
    blank(4);
    n_checks++;
    if (value[15:12] !== 4'h1) $display("FAIL glitch_slot3: got %h, required 1", value[15:12]);
    else n_pass++;
  endtask

  task automatic test_invalid_glyph();
    drive_digit(0, 7'h01, 8);
    blank(3);
    check_bit("invalid_seg_err", seg_err, 1'b1);
    check_bit("invalid_mask0", digit_mask[0], 1'b0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_bit("invalid_err_clr", seg_err, 1'b0);
    // err_clr lands on the capture edge of a second invalid glyph: the error wins.
    an = 8'hFE; a_to_g = ~7'h00;
    repeat (4) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_bit("invalid_err_wins", seg_err, 1'b1);
    blank(3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_double_anode();
    an = 8'b1111_1100; a_to_g = ~glyph(4'h8);
    repeat (6) @(negedge clk);
    check_bit("double_an_err", an_err, 1'b1);
    n_checks++;
    if (digit_mask !== 8'h0) $display("FAIL double_mask: got %h, required 0", digit_mask);
    else n_pass++;
    check_bit("double_seg_err", seg_err, 1'b0);
    blank(3);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_bit("double_err_clr", an_err, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    for (int d = 7; d >= 3; d--) drive_digit(d, glyph(4'(d)), 10);
    n_checks++;
    if (digit_mask !== 8'hF8) $display("FAIL midrst_partial: got %h, required f8", digit_mask);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (digit_mask !== 8'h0) $display("FAIL midrst_mask: got %h, required 0", digit_mask);
    else n_pass++;
    n_checks++;
    if (value !== 32'h0) $display("FAIL midrst_value: got %h, required 0", value);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    scan(32'h12345678);
    blank(4);
    n_checks++;
    if (value !== 32'h12345678) $display("FAIL midrst_rescan: got %h, required 12345678", value);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) scan($urandom);
    blank(5);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL b2b_frames: got %0d pending, required 0", exp_q.size());
    else n_pass++;
  endtask

`ifdef SEG_MONITOR_TIMEOUT_EN
  task automatic test_timeout();
    blank(1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (99) @(negedge clk);
    check_bit("timeout_before", stale, 1'b0);
    @(negedge clk);
    check_bit("timeout_at_limit", stale, 1'b1);
    repeat (20) @(negedge clk);
    check_bit("timeout_holds", stale, 1'b1);
    scan(32'hCAFE0123);
    blank(3);
    check_bit("timeout_cleared", stale, 1'b0);
  endtask
`else
  task automatic test_timeout();
    blank(150);
    check_bit("stale_tied_low", stale, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_deadbeef();
    test_glitch();
    test_invalid_glyph();
    test_double_anode();
    test_reset_mid_frame();
    test_back_to_back();
    test_timeout();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL final_frames: got %0d pending, required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
